// File: rtl/motion_timing_pkg.sv
// Shared constants, index names and state types for the per-axis move-duration calculator.
package motion_timing_pkg;

  localparam int unsigned CLK_FREQ = 50_000_000;
  localparam int          NUM_AXES = 5;

  localparam int P_V0 = 0;
  localparam int P_V  = 1;
  localparam int P_A  = 2;
  localparam int P_NA = 3;
  localparam int P_N  = 4;

  localparam int T_ACC    = 0;
  localparam int T_CRUISE = 1;
  localparam int T_DEC    = 2;
  localparam int T_TOTAL  = 3;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [1:0] {PH_LOAD1, PH_WAIT1, PH_WAIT2} phase_t;

  // Steps (or speed difference) scaled to clock ticks; always fits in 64 bits.
  function automatic logic [63:0] to_ticks(input logic [31:0] n);
    return 64'(n) * 64'(CLK_FREQ);
  endfunction

endpackage

// File: rtl/seq_divider_64x32.sv
// Restoring 64/32 unsigned divider: one load cycle, 64 iterations, one-cycle done pulse.
module seq_divider_64x32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [63:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [63:0] quotient
);

  logic [63:0] quo_r;
  logic [31:0] rem_r;
  logic [31:0] dvs_r;
  logic [5:0]  cnt_r;
  logic        dz_r;

  logic [32:0] shifted;
  logic [31:0] diff;
  logic        fits;

  // Remainder stays below the divisor, so the low 32 bits of the difference are exact.
  always_comb begin
    shifted = {rem_r, quo_r[63]};
    diff    = shifted[31:0] - dvs_r;
    fits    = shifted >= {1'b0, dvs_r};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      quo_r <= '0;
      rem_r <= '0;
      dvs_r <= '0;
      cnt_r <= '0;
      dz_r  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        quo_r <= dividend;
        rem_r <= '0;
        dvs_r <= divisor;
        dz_r  <= (divisor == '0);
        cnt_r <= '0;
        busy  <= 1'b1;
      end else if (busy) begin
        rem_r <= fits ? diff : shifted[31:0];
        quo_r <= {quo_r[62:0], fits};
        cnt_r <= cnt_r + 6'd1;
        if (cnt_r == 6'd63) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = dz_r ? '0 : quo_r;

endmodule

// File: rtl/motion_timing_calc.sv
// Serial trapezoidal-profile duration calculator for five axes sharing one divider.
module motion_timing_calc
  import motion_timing_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] params_x  [0:4],
  input  logic [31:0] params_y  [0:4],
  input  logic [31:0] params_z  [0:4],
  input  logic [31:0] params_e0 [0:4],
  input  logic [31:0] params_e1 [0:4],
  output logic [63:0] timing_x  [0:3],
  output logic [63:0] timing_y  [0:3],
  output logic [63:0] timing_z  [0:3],
  output logic [63:0] timing_e0 [0:3],
  output logic [63:0] timing_e1 [0:3],
  output logic        busy,
  output logic        finish
);

  state_t      state, state_next;
  phase_t      phase, phase_next;
  logic [2:0]  axis, axis_next;

  logic [31:0] prm      [NUM_AXES][5];
  logic [63:0] timing_r [NUM_AXES][4];
  logic [63:0] t_acc_r;

  logic        latch_en, acc_capture, sum_en;
  logic        div_load, div_busy, div_done;
  logic [63:0] div_dividend, div_quotient;
  logic [31:0] div_divisor;

  logic [31:0] v0, v, a, n_a, n;
  logic [32:0] two_na;
  logic [31:0] cruise_steps;
  logic        acc_ok, cruise_ok;

  // Guards force a zero dividend and a divisor of 1, so a zero divisor never reaches the divider.
  always_comb begin
    v0           = prm[axis][P_V0];
    v            = prm[axis][P_V];
    a            = prm[axis][P_A];
    n_a          = prm[axis][P_NA];
    n            = prm[axis][P_N];
    two_na       = {n_a, 1'b0};
    cruise_steps = ({1'b0, n} > two_na) ? (n - two_na[31:0]) : '0;
    acc_ok       = (n != '0) && (a != '0) && (v > v0);
    cruise_ok    = (v != '0) && (cruise_steps != '0);
    if (phase == PH_LOAD1) begin
      div_dividend = acc_ok ? to_ticks(v - v0) : '0;
      div_divisor  = acc_ok ? a : 32'd1;
    end else begin
      div_dividend = cruise_ok ? to_ticks(cruise_steps) : '0;
      div_divisor  = cruise_ok ? v : 32'd1;
    end
  end

  seq_divider_64x32 u_div (
    .clk      (clk),
    .reset    (reset),
    .load     (div_load),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      phase <= PH_LOAD1;
      axis  <= '0;
    end else begin
      state <= state_next;
      phase <= phase_next;
      axis  <= axis_next;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    phase_next  = phase;
    axis_next   = axis;
    latch_en    = 1'b0;
    acc_capture = 1'b0;
    sum_en      = 1'b0;
    div_load    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = CALC;
          phase_next = PH_LOAD1;
          axis_next  = '0;
          latch_en   = 1'b1;
        end
      end
      CALC: begin
        case (phase)
          PH_LOAD1: begin
            div_load = !div_busy;
            if (!div_busy) phase_next = PH_WAIT1;
          end
          PH_WAIT1: begin
            if (div_done) begin
              acc_capture = 1'b1;
              div_load    = 1'b1;
              phase_next  = PH_WAIT2;
            end
          end
          PH_WAIT2: begin
            if (div_done) begin
              sum_en = 1'b1;
              if (axis == 3'(NUM_AXES - 1)) begin
                state_next = DONE;
              end else begin
                axis_next  = axis + 3'd1;
                phase_next = PH_LOAD1;
              end
            end
          end
          default: phase_next = PH_LOAD1;
        endcase
      end
      DONE: begin
        if (!start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the result array is a small flop bank reset asynchronously, so an abort leaves only zeros.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_AXES; i++) begin
        for (int j = 0; j < 5; j++) prm[i][j] <= '0;
        for (int j = 0; j < 4; j++) timing_r[i][j] <= '0;
      end
      t_acc_r <= '0;
    end else begin
      if (latch_en) begin
        prm[0] <= params_x;
        prm[1] <= params_y;
        prm[2] <= params_z;
        prm[3] <= params_e0;
        prm[4] <= params_e1;
      end
      if (acc_capture) t_acc_r <= div_quotient;
      if (sum_en) begin
        timing_r[axis][T_ACC]    <= t_acc_r;
        timing_r[axis][T_CRUISE] <= div_quotient;
        timing_r[axis][T_DEC]    <= t_acc_r;
        timing_r[axis][T_TOTAL]  <= t_acc_r + div_quotient + t_acc_r;
      end
    end
  end

  assign timing_x  = timing_r[0];
  assign timing_y  = timing_r[1];
  assign timing_z  = timing_r[2];
  assign timing_e0 = timing_r[3];
  assign timing_e1 = timing_r[4];

  assign busy   = (state == CALC);
  assign finish = (state == DONE);

endmodule

// File: tb/tb_motion_timing_calc.sv
// Scoreboard bench: runs push expected timings, a monitor compares them on each finish rise.
module tb_motion_timing_calc;

  localparam int unsigned LATENCY = 656;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] params_x  [0:4];
  logic [31:0] params_y  [0:4];
  logic [31:0] params_z  [0:4];
  logic [31:0] params_e0 [0:4];
  logic [31:0] params_e1 [0:4];
  logic [63:0] timing_x  [0:3];
  logic [63:0] timing_y  [0:3];
  logic [63:0] timing_z  [0:3];
  logic [63:0] timing_e0 [0:3];
  logic [63:0] timing_e1 [0:3];
  logic        busy;
  logic        finish;

  motion_timing_calc dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .params_x  (params_x),
    .params_y  (params_y),
    .params_z  (params_z),
    .params_e0 (params_e0),
    .params_e1 (params_e1),
    .timing_x  (timing_x),
    .timing_y  (timing_y),
    .timing_z  (timing_z),
    .timing_e0 (timing_e0),
    .timing_e1 (timing_e1),
    .busy      (busy),
    .finish    (finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] prm    [5][5];
  logic [63:0] exp_tb [5][4];
  logic [63:0] exp_q  [$];
  int unsigned lat_q  [$];
  int unsigned last_start;
  logic        mon_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] dut_t(input int ax, input int k);
    case (ax)
      0:       return timing_x[k];
      1:       return timing_y[k];
      2:       return timing_z[k];
      3:       return timing_e0[k];
      default: return timing_e1[k];
    endcase
  endfunction

  task automatic clear_all();
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) prm[i][j] = '0;
      for (int j = 0; j < 4; j++) exp_tb[i][j] = '0;
    end
  endtask

  task automatic set_axis(input int ax, input logic [31:0] v0, input logic [31:0] v,
                          input logic [31:0] a, input logic [31:0] na, input logic [31:0] n);
    prm[ax][0] = v0;
    prm[ax][1] = v;
    prm[ax][2] = a;
    prm[ax][3] = na;
    prm[ax][4] = n;
  endtask

  task automatic expect_axis(input int ax, input logic [63:0] t0, input logic [63:0] t1,
                             input logic [63:0] t2, input logic [63:0] t3);
    exp_tb[ax][0] = t0;
    exp_tb[ax][1] = t1;
    exp_tb[ax][2] = t2;
    exp_tb[ax][3] = t3;
  endtask

  task automatic load_params();
    params_x  = prm[0];
    params_y  = prm[1];
    params_z  = prm[2];
    params_e0 = prm[3];
    params_e1 = prm[4];
  endtask

  task automatic check_all_zero(input string tag);
    for (int ax = 0; ax < 5; ax++)
      for (int k = 0; k < 4; k++)
        check($sformatf("%s_t[%0d][%0d]", tag, ax, k), dut_t(ax, k), 64'd0);
  endtask

  // Called at a negedge with the DUT idle; leaves the bench one negedge after start was sampled.
  task automatic start_run();
    load_params();
    start      = 1'b1;
    last_start = cyc;
    lat_q.push_back(cyc);
    for (int ax = 0; ax < 5; ax++)
      for (int k = 0; k < 4; k++) exp_q.push_back(exp_tb[ax][k]);
    check("busy_before_start", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("busy_rise", {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_finish();
    int n = 0;
    while (!finish && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("finish_seen", {63'd0, finish}, 64'd1);
  endtask

  // Monitor: compares the oldest expected result set whenever finish rises.
  initial begin
    forever begin
      @(negedge clk);
      if (finish && !mon_prev) begin
        if (lat_q.size() == 0 || exp_q.size() < 20) begin
          checks++;
          errors++;
          $display("FAIL unexpected_finish at cycle %0d with no expected result queued", cyc);
        end else begin
          check("finish_latency", 64'(cyc - lat_q.pop_front()), 64'(LATENCY));
          check("busy_at_done", {63'd0, busy}, 64'd0);
          for (int ax = 0; ax < 5; ax++)
            for (int k = 0; k < 4; k++)
              check($sformatf("timing[%0d][%0d]", ax, k), dut_t(ax, k), exp_q.pop_front());
        end
      end
      mon_prev = finish;
    end
  end

  initial begin
    #300_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic held_ok;
    reset = 1'b0;
    start = 1'b0;
    clear_all();
    load_params();
    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_finish", {63'd0, finish}, 64'd0);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // Run 1: x only; z has v <= v0 and v = 0; e0 has N = 0 with nonzero speeds.
    clear_all();
    set_axis(0, 1000, 5000, 10000, 1200, 4000);
    set_axis(2, 0, 0, 100, 0, 50);
    set_axis(3, 10, 20, 5, 1, 0);
    expect_axis(0, 64'd20_000_000, 64'd16_000_000, 64'd20_000_000, 64'd56_000_000);
    start_run();
    wait_finish();
    start = 1'b0;
    @(negedge clk);
    check("finish_clear_r1", {63'd0, finish}, 64'd0);

    // Run 2: start held for 1000 cycles; finish must hold until start falls.
    start_run();
    wait_finish();
    held_ok = 1'b1;
    while (cyc - last_start < 1000) begin
      if (!finish) held_ok = 1'b0;
      @(negedge clk);
    end
    check("finish_held", {63'd0, held_ok}, 64'd1);
    start = 1'b0;
    @(negedge clk);
    check("finish_clear_r2", {63'd0, finish}, 64'd0);

    // Run 3: immediate restart with identical parameters.
    start_run();
    wait_finish();
    start = 1'b0;
    @(negedge clk);

    // Abort: reset asserted 300 cycles into a computation.
    clear_all();
    set_axis(0, 100, 600, 0, 0, 200);
    set_axis(1, 2000, 2000, 0, 0, 1000);
    set_axis(2, 100, 1100, 1000, 600, 1000);
    load_params();
    start = 1'b1;
    repeat (300) @(negedge clk);
    check("busy_mid_calc", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_finish", {63'd0, finish}, 64'd0);
    check_all_zero("abort");
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Run 4: a = 0 with v > v0, constant speed, and a short move with 2*n_a > N.
    expect_axis(0, 64'd0, 64'd16_666_666, 64'd0, 64'd16_666_666);
    expect_axis(1, 64'd0, 64'd25_000_000, 64'd0, 64'd25_000_000);
    expect_axis(2, 64'd50_000_000, 64'd0, 64'd50_000_000, 64'd100_000_000);
    start_run();
    wait_finish();
    start = 1'b0;
    @(negedge clk);

    // Run 5: five distinct axes, truncation, results above 2^32; start dropped mid-calc.
    clear_all();
    set_axis(0, 1000, 5000, 10000, 1200, 4000);
    set_axis(1, 2000, 2000, 0, 0, 1000);
    set_axis(2, 100, 1100, 1000, 600, 1000);
    set_axis(3, 0, 3, 7, 10, 1000);
    set_axis(4, 3000, 2500, 500, 100, 700);
    expect_axis(0, 64'd20_000_000, 64'd16_000_000, 64'd20_000_000, 64'd56_000_000);
    expect_axis(1, 64'd0, 64'd25_000_000, 64'd0, 64'd25_000_000);
    expect_axis(2, 64'd50_000_000, 64'd0, 64'd50_000_000, 64'd100_000_000);
    expect_axis(3, 64'd21_428_571, 64'd16_333_333_333, 64'd21_428_571, 64'd16_376_190_475);
    expect_axis(4, 64'd0, 64'd10_000_000, 64'd0, 64'd10_000_000);
    start_run();
    repeat (9) @(negedge clk);
    start = 1'b0;
    check("busy_after_start_drop", {63'd0, busy}, 64'd1);
    wait_finish();
    @(negedge clk);
    check("finish_single_pulse", {63'd0, finish}, 64'd0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
